// File: rtl/pll_reconfig_pkg.sv
// rtl/pll_reconfig_pkg.sv - register map, counter-word encoding and PAL/NTSC write tables
package pll_reconfig_pkg;

  localparam logic [5:0] ADDR_MODE   = 6'h00;
  localparam logic [5:0] ADDR_STATUS = 6'h01;
  localparam logic [5:0] ADDR_START  = 6'h02;
  localparam logic [5:0] ADDR_M      = 6'h04;
  localparam logic [5:0] ADDR_C      = 6'h05;
  localparam logic [5:0] ADDR_K      = 6'h07;

  localparam int unsigned CFG_ENTRIES = 7;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } cfg_entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_POLL_RD,
    S_POLL_WT,
    S_LOCK_WT,
    S_FIN
  } state_t;

  // cnt_idx selects which C counter a C-register write targets; zero for M
  function automatic logic [31:0] counter_word(input logic [4:0] cnt_idx,
                                               input logic       odd_en,
                                               input logic       bypass,
                                               input logic [7:0] hi,
                                               input logic [7:0] lo);
    return {9'd0, cnt_idx, odd_en, bypass, hi, lo};
  endfunction

  localparam cfg_entry_t PAL_CFG [CFG_ENTRIES] = '{
    '{ADDR_MODE,  32'd1},
    '{ADDR_M,     counter_word(5'd0, 1'b1, 1'b0, 8'd6, 8'd5)},
    '{ADDR_K,     32'd1503512573},
    '{ADDR_C,     counter_word(5'd0, 1'b0, 1'b0, 8'd6, 8'd6)},
    '{ADDR_C,     counter_word(5'd1, 1'b1, 1'b0, 8'd5, 8'd4)},
    '{ADDR_C,     counter_word(5'd2, 1'b0, 1'b0, 8'd9, 8'd9)},
    '{ADDR_START, 32'd1}
  };

  localparam cfg_entry_t NTSC_CFG [CFG_ENTRIES] = '{
    '{ADDR_MODE,  32'd1},
    '{ADDR_M,     counter_word(5'd0, 1'b1, 1'b0, 8'd7, 8'd6)},
    '{ADDR_K,     32'd1288490189},
    '{ADDR_C,     counter_word(5'd0, 1'b0, 1'b0, 8'd7, 8'd7)},
    '{ADDR_C,     counter_word(5'd1, 1'b0, 1'b0, 8'd5, 8'd5)},
    '{ADDR_C,     counter_word(5'd2, 1'b1, 1'b0, 8'd10, 8'd9)},
    '{ADDR_START, 32'd1}
  };

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser for a single asynchronous level
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reconfig_seq.sv
// rtl/pll_reconfig_seq.sv - reprograms the system PLL through its reconfig controller on a PAL/NTSC change
module pll_reconfig_seq
  import pll_reconfig_pkg::*;
#(
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned POLL_LIMIT   = 4095
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mode_sel,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic        mgmt_read,
  output logic [31:0] mgmt_writedata,
  input  logic [31:0] mgmt_readdata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked,
  output logic        busy,
  output logic        done,
  output logic        error
);

  logic [1:0]  rst_pipe;
  logic        rst_n;
  logic        mode_s;
  logic        locked_s;
  state_t      state;
  logic        cur_mode;
  logic        tgt_mode;
  logic [2:0]  idx;
  logic [31:0] poll_cnt;
  logic [31:0] lock_cnt;
  logic [3:0]  stable_cnt;
  cfg_entry_t  entry;
  logic        unused_rdata;

  // Reset asserts immediately but releases on a clock edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_pipe <= 2'b00;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign rst_n = rst_pipe[1];

  sync2 u_sync_mode (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (mode_sel),
    .q     (mode_s)
  );

  sync2 u_sync_lock (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  assign entry        = tgt_mode ? NTSC_CFG[idx] : PAL_CFG[idx];
  assign unused_rdata = ^mgmt_readdata[31:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cur_mode       <= 1'b0;
      tgt_mode       <= 1'b0;
      idx            <= 3'd0;
      poll_cnt       <= 32'd0;
      lock_cnt       <= 32'd0;
      stable_cnt     <= 4'd0;
      mgmt_address   <= 6'd0;
      mgmt_writedata <= 32'd0;
      mgmt_write     <= 1'b0;
      mgmt_read      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mode_s != cur_mode) begin
            tgt_mode <= mode_s;
            idx      <= 3'd0;
            busy     <= 1'b1;
            error    <= 1'b0;
            state    <= S_LOAD;
          end
        end

        S_LOAD: begin
          mgmt_address   <= entry.addr;
          mgmt_writedata <= entry.data;
          mgmt_write     <= 1'b1;
          state          <= S_WRITE;
        end

        S_WRITE: begin
          if (!mgmt_waitrequest) begin
            mgmt_write <= 1'b0;
            if (idx == 3'(CFG_ENTRIES - 1)) begin
              mgmt_address   <= ADDR_STATUS;
              mgmt_writedata <= 32'd0;
              mgmt_read      <= 1'b1;
              poll_cnt       <= 32'd0;
              state          <= S_POLL_RD;
            end else begin
              idx   <= idx + 3'd1;
              state <= S_LOAD;
            end
          end
        end

        S_POLL_RD: begin
          if (!mgmt_waitrequest) begin
            mgmt_read <= 1'b0;
            state     <= S_POLL_WT;
          end
        end

        // readdata is valid in this cycle, one after the read was accepted
        S_POLL_WT: begin
          if (mgmt_readdata[0]) begin
            lock_cnt   <= 32'd0;
            stable_cnt <= 4'd0;
            state      <= S_LOCK_WT;
          end else if (poll_cnt + 32'd1 >= POLL_LIMIT) begin
            error <= 1'b1;
            state <= S_FIN;
          end else begin
            poll_cnt  <= poll_cnt + 32'd1;
            mgmt_read <= 1'b1;
            state     <= S_POLL_RD;
          end
        end

        // stable_cnt holds the number of consecutive locked cycles before this one
        S_LOCK_WT: begin
          if (locked_s && stable_cnt == 4'd15) begin
            cur_mode <= tgt_mode;
            done     <= 1'b1;
            state    <= S_FIN;
          end else if (lock_cnt + 32'd1 >= LOCK_TIMEOUT) begin
            error <= 1'b1;
            state <= S_FIN;
          end else begin
            lock_cnt   <= lock_cnt + 32'd1;
            stable_cnt <= locked_s ? stable_cnt + 4'd1 : 4'd0;
          end
        end

        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// tb/tb_pll_reconfig_seq.sv - scoreboard bench for pll_reconfig_seq
module tb_pll_reconfig_seq;

  localparam int LT = 300;
  localparam int PL = 20;
  localparam int K_WR = 0, K_RD = 1, K_DONE = 2, K_ERR = 3;

  typedef struct {
    int          kind;
    logic [5:0]  addr;
    logic [31:0] data;
  } ev_t;

  logic        clk;
  logic        reset_n;
  logic        mode_sel;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic        mgmt_read;
  logic [31:0] mgmt_writedata;
  logic [31:0] mgmt_readdata;
  logic        mgmt_waitrequest;
  logic        pll_locked;
  logic        busy;
  logic        done;
  logic        error;

  ev_t         exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          ev_cnt = 0;
  int          cyc = 0;
  int          rd_n = 0;
  int          ok_on_read = 1;
  int          last_rd_cyc = 0;
  int          err_lat = 0;
  int          stall_left = 0;
  bit          stall_en = 0;
  bit          force_stall = 0;
  bit          err_seen = 0;
  bit          hold_v = 0;
  bit          prev_err = 0;
  bit          prev_done = 0;
  logic [5:0]  hold_a;
  logic [31:0] hold_d;

  logic [5:0]  exp_addr [7] = '{6'h00, 6'h04, 6'h07, 6'h05, 6'h05, 6'h05, 6'h02};
  logic [31:0] pal_data [7] = '{32'd1, 32'h00020605, 32'd1503512573, 32'h00000606,
                                32'h00060504, 32'h00080909, 32'd1};
  logic [31:0] ntsc_data[7] = '{32'd1, 32'h00020706, 32'd1288490189, 32'h00000707,
                                32'h00040505, 32'h000A0A09, 32'd1};

  pll_reconfig_seq #(
    .LOCK_TIMEOUT (LT),
    .POLL_LIMIT   (PL)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .mode_sel         (mode_sel),
    .mgmt_address     (mgmt_address),
    .mgmt_write       (mgmt_write),
    .mgmt_read        (mgmt_read),
    .mgmt_writedata   (mgmt_writedata),
    .mgmt_readdata    (mgmt_readdata),
    .mgmt_waitrequest (mgmt_waitrequest),
    .pll_locked       (pll_locked),
    .busy             (busy),
    .done             (done),
    .error            (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic take(input int k, input logic [5:0] a, input logic [31:0] d);
    ev_t e;
    n_checks++;
    ev_cnt++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event actual kind=%0d addr=%h data=%h required none", k, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.addr !== a || e.data !== d) begin
        n_fail++;
        $display("FAIL event actual kind=%0d addr=%h data=%h required kind=%0d addr=%h data=%h",
                 k, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  task automatic push_seq(input bit ntsc, input int reads, input bit ok);
    for (int i = 0; i < 7; i++)
      exp_q.push_back('{K_WR, exp_addr[i], ntsc ? ntsc_data[i] : pal_data[i]});
    for (int i = 0; i < reads; i++)
      exp_q.push_back('{K_RD, 6'h01, 32'd0});
    exp_q.push_back('{ok ? K_DONE : K_ERR, 6'd0, 32'd0});
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (60) @(negedge clk);
    chk({name, "_busy_idle"}, {31'd0, busy}, 0);
    chk({name, "_error_idle"}, {31'd0, error}, 0);
  endtask

  // Controller model: stalls and status reads
  always @(posedge clk) begin
    #1;
    if (force_stall) begin
      mgmt_waitrequest = 1'b1;
    end else if (stall_en && (mgmt_write || mgmt_read)) begin
      if (stall_left > 0) begin
        mgmt_waitrequest = 1'b1;
        stall_left--;
      end else begin
        mgmt_waitrequest = 1'b0;
        stall_left = $urandom_range(0, 5);
      end
    end else begin
      mgmt_waitrequest = 1'b0;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (reset_n) begin
      if (mgmt_write && mgmt_read) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_wr_exclusive actual=both required=one");
      end
      if ((mgmt_write || mgmt_read) && hold_v) begin
        chk("stall_addr_hold", {26'd0, mgmt_address}, {26'd0, hold_a});
        chk("stall_data_hold", mgmt_writedata, hold_d);
      end
      hold_v = (mgmt_write || mgmt_read) && mgmt_waitrequest;
      hold_a = mgmt_address;
      hold_d = mgmt_writedata;
      if (mgmt_write && !mgmt_waitrequest) begin
        take(K_WR, mgmt_address, mgmt_writedata);
        if (mgmt_address == 6'h02) rd_n = 0;
      end
      if (mgmt_read && !mgmt_waitrequest) begin
        take(K_RD, mgmt_address, 32'd0);
        rd_n++;
        mgmt_readdata = (rd_n >= ok_on_read) ? 32'd1 : 32'd0;
        last_rd_cyc = cyc;
      end
      if (done) begin
        take(K_DONE, 6'd0, 32'd0);
        chk("done_one_cycle", {31'd0, prev_done}, 0);
      end
      if (error && !prev_err) begin
        take(K_ERR, 6'd0, 32'd0);
        err_seen = 1;
        err_lat = cyc - last_rd_cyc;
      end
      prev_err = error;
      prev_done = done;
    end else begin
      hold_v = 0;
      prev_err = 0;
      prev_done = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int t;
    int ev0;
    reset_n = 1'b0;
    mode_sel = 1'b0;
    pll_locked = 1'b1;
    mgmt_waitrequest = 1'b0;
    mgmt_readdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_write", {31'd0, mgmt_write}, 0);
    chk("rst_read", {31'd0, mgmt_read}, 0);
    chk("rst_addr", {26'd0, mgmt_address}, 0);
    chk("rst_wdata", mgmt_writedata, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_error", {31'd0, error}, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Idle in PAL: no bus traffic
    repeat (1000) @(negedge clk);
    chk("idle_events", ev_cnt, 0);
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_error", {31'd0, error}, 0);

    // PAL -> NTSC, status done on third read
    ok_on_read = 3;
    push_seq(1'b1, 3, 1'b1);
    @(posedge clk); #1;
    mode_sel = 1'b1;
    drain("pal_to_ntsc");

    // NTSC -> PAL with random stalls
    ok_on_read = 2;
    stall_en = 1;
    push_seq(1'b0, 2, 1'b1);
    @(posedge clk); #1;
    mode_sel = 1'b0;
    drain("ntsc_to_pal_stall");
    stall_en = 0;

    // PAL -> NTSC with mode_sel bouncing 1->0->1 mid-sequence
    ok_on_read = 1;
    push_seq(1'b1, 1, 1'b1);
    ev0 = ev_cnt;
    @(posedge clk); #1;
    mode_sel = 1'b1;
    t = 0;
    while (ev_cnt == ev0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("toggle_first_write_seen", {31'd0, ev_cnt > ev0}, 1);
    repeat (2) @(posedge clk); #1;
    mode_sel = 1'b0;
    repeat (3) @(posedge clk); #1;
    mode_sel = 1'b1;
    drain("toggle_single_seq");

    // NTSC -> PAL with no relock: timeout, then automatic retry succeeds
    pll_locked = 1'b0;
    err_seen = 0;
    push_seq(1'b0, 1, 1'b0);
    push_seq(1'b0, 1, 1'b1);
    @(posedge clk); #1;
    mode_sel = 1'b0;
    t = 0;
    while (!err_seen && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("lock_timeout_error_seen", {31'd0, err_seen}, 1);
    chk("lock_timeout_latency", err_lat, LT + 2);
    pll_locked = 1'b1;
    drain("lock_retry");

    // Reset while a write is stalled, then NTSC sequence reruns in full
    force_stall = 1;
    @(posedge clk); #1;
    mode_sel = 1'b1;
    t = 0;
    while (!mgmt_write && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("stalled_write_present", {31'd0, mgmt_write}, 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_write", {31'd0, mgmt_write}, 0);
    chk("async_rst_busy", {31'd0, busy}, 0);
    force_stall = 0;
    ok_on_read = 1;
    repeat (3) @(posedge clk); #1;
    push_seq(1'b1, 1, 1'b1);
    reset_n = 1'b1;
    drain("post_reset_rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_reconfig_seq.md
Name: pll_reconfig_seq

Overview:
- Sequencer upstream of the reconfigurable system PLL's reconfiguration controller.
- On a video-standard change it reprograms the M, K (fractional) and C0–C2 counters through the controller's Avalon-MM management port, starts reconfiguration and waits for relock.
- Outcomes: PAL core clocks 47.291931 / 63.055908 / 31.527954 MHz; NTSC core clocks come from the NTSC table.
- Sits between the core's mode/OSD logic and the PLL reconfig controller, in the clk domain.

Parameters:
- LOCK_TIMEOUT, 65535: cycles to wait for pll_locked after the reconfig status reports done, before flagging an error.
- POLL_LIMIT, 4095: maximum status reads before flagging an error.

Ports:
- clk  in  1  management clock (50 MHz reference domain)
- reset_n  in  1  asynchronous active-low reset
- mode_sel  in  1  0=PAL, 1=NTSC; asynchronous to clk, synchronised internally
- mgmt_address  out  6  controller register address
- mgmt_write  out  1  write strobe
- mgmt_read  out  1  read strobe
- mgmt_writedata  out  32  write data
- mgmt_readdata  in  32  read data, valid in the cycle after mgmt_read is accepted
- mgmt_waitrequest  in  1  controller stall
- pll_locked  in  1  PLL lock, asynchronous, synchronised internally
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse on successful relock
- error  out  1  sticky; cleared at the start of the next sequence

Behaviour:
- Reset (async assert, sync deassert internally):
  - Outputs: mgmt_write=0, mgmt_read=0, mgmt_address=0, mgmt_writedata=0, busy=0, done=0, error=0.
  - cur_mode=0, i.e. PAL, which is the PLL's power-on configuration.
- Synchronisers: mode_sel and pll_locked each pass through 2 flops. A request is raised when mode_s != cur_mode while in IDLE.
- FSM states: IDLE, LOAD, WRITE, POLL_RD, POLL_WT, LOCK_WT, FIN.
- IDLE:
  - On request, capture tgt_mode=mode_s, set idx=0, busy=1, error=0, then go to LOAD.
- LOAD:
  - Drive address/data from table[tgt_mode][idx], then go to WRITE the next cycle.
- WRITE:
  - mgmt_write=1 and address/data are held stable while mgmt_waitrequest=1.
  - The write is accepted in the first cycle with waitrequest=0. mgmt_write drops the following cycle.
  - If idx=5, go to POLL_RD. Otherwise idx+1 and go to LOAD.
- Write table (order fixed, 6 entries):
  - addr 0x00 data 1 (polling mode)
  - addr 0x04 M
  - addr 0x07 K
  - addr 0x05 C0
  - addr 0x05 C1
  - addr 0x05 C2
- Data encoding:
  - Counter word = {odd_en at bit17, bypass at bit16, hi[15:8], lo[7:0]}.
  - C words additionally carry the counter index in bits [22:18].
- Start write:
  - After entry 5, one extra write of addr 0x02, data 1 (start) is issued before POLL_RD.
  - Implementation: a 7-entry table whose last entry is the start write.
- PAL table:
  - M = 0x00020605
  - K = 1503512573
  - C0 = 0x00000606
  - C1 = 0x00060504
  - C2 = 0x00080909
- NTSC table: the package constant NTSC_CFG, produced by the PLL tool for the NTSC frequency plan. It uses the same encoding and its values are fixed in the package.
- POLL_RD / POLL_WT:
  - Read addr 0x01 with the same waitrequest rule as writes.
  - The cycle after acceptance, sample readdata[0]. If 1, go to LOCK_WT. Otherwise increment the poll count and re-read.
  - When the count reaches POLL_LIMIT: error=1, go to FIN without updating cur_mode.
- LOCK_WT:
  - Counter starts at 0 and requires pll_locked_s=1 for 16 consecutive cycles.
  - On success: cur_mode=tgt_mode, go to FIN.
  - Counter reaching LOCK_TIMEOUT: error=1, go to FIN.
- FIN:
  - done=1 for one cycle only on success.
  - busy=0 in the cycle after FIN; return to IDLE.
  - If mode_s still differs from cur_mode, a new sequence starts from IDLE. After an error this re-arms, so retries are automatic.
- mode_sel changes while busy are ignored until FIN. Only the final value matters, so there is no queueing.
- Reset mid-sequence aborts immediately with strobes low. The PLL is left as is and cur_mode returns to PAL; a held NTSC select then triggers a fresh full sequence.
- mgmt_write and mgmt_read are never asserted together.

Decomposition:
- Package pll_reconfig_pkg:
  - register address constants: MODE, STATUS, START, M, C, K
  - counter-word encode function
  - cfg_entry_t record (addr, data)
  - PAL_CFG and NTSC_CFG 7-entry arrays
- Sub-module: none beyond a reusable sync2 synchroniser instanced twice. The FSM stays in one module.

Test Plan:
- Reset, mode_sel=0, waitrequest=0: no bus activity for 1000 cycles; busy=0, error=0.
- mode_sel 0→1, waitrequest=0, status bit0=1 on the 3rd read, locked held:
  - expect 7 writes in order 0x00, 0x04, 0x07, 0x05 ×3, 0x02 with NTSC_CFG data
  - then 3 reads of 0x01, then done pulse; cur_mode=1.
- NTSC→PAL with waitrequest randomly high for 0–5 cycles per access:
  - address/data stay stable while stalled
  - data words exactly 1, 0x00020605, 1503512573, 0x00000606, 0x00060504, 0x00080909, 1.
- pll_locked held 0 after status done: error=1 after LOCK_TIMEOUT cycles, no done pulse, and the sequence restarts automatically.
- Toggle mode_sel 1→0→1 during a write sequence: exactly one sequence completes with cur_mode=1 and no second sequence follows.
- Assert reset_n low while mgmt_write=1 and waitrequest=1: mgmt_write=0 asynchronously, busy=0; after release with mode_sel=1, the full NTSC sequence reruns.
